// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage.
// State encoding, bus widths and the queued fetch entry layout.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Handshake bundles for the fetch stage.
// imem_if: req/ack to instruction memory; instr_if: valid/ready to decode.
interface imem_if;
    import fetch_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

interface instr_if;
    import fetch_pkg::*;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    modport master (
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue; clear wins over push and pop.
// Ports: push/din, pop, clear, count, head (zero when empty).
module fetch_queue #(
    parameter  int QDEPTH = 2,
    parameter  int W      = 64,
    localparam int CW     = $clog2(QDEPTH + 1),
    localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    // A full queue may still accept a push when the head leaves
    assign do_push = push && ((count < CW'(QDEPTH)) || do_pop);
    assign head    = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one memory request per new pc, queued to decode.
// Ports: clk, rst_n, pc, flush, imem (req/ack master), dec (valid/ready master).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    imem_if.master            imem,
    instr_if.master           dec
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] last_pc_q;
    logic [ADDR_W-1:0] last_pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              force_q;
    logic              force_d;
    logic              req_q;
    logic              req_d;
    logic              push;
    logic              pop;
    logic              trigger;
    logic [CW-1:0]     count;
    fetch_entry_t      push_e;
    fetch_entry_t      head_e;

    assign trigger = ((pc != last_pc_q) || force_q)
                   && (count < CW'(QDEPTH)) && !flush;

    always_comb begin
        state_d   = state_q;
        last_pc_d = last_pc_q;
        addr_d    = addr_q;
        force_d   = force_q;
        req_d     = req_q;
        push      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d   = REQ;
                    addr_d    = pc;
                    last_pc_d = pc;
                    force_d   = 1'b0;
                    req_d     = 1'b1;
                end
            end
            REQ: begin
                if (imem.imem_ack) begin
                    push    = !flush;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (flush) begin
                    // Request stays up: memory must finish the beat
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem.imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
        // Redirect may land on last_pc, so force a refetch
        if (flush) begin
            force_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_pc_q <= '0;
            addr_q    <= '0;
            force_q   <= 1'b1;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_pc_q <= last_pc_d;
            addr_q    <= addr_d;
            force_q   <= force_d;
            req_q     <= req_d;
        end
    end

    assign push_e = '{pc: addr_q, instr: imem.imem_data};
    assign pop    = dec.instr_valid && dec.instr_ready;

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .W      (ENTRY_W)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_e),
        .pop   (pop),
        .clear (flush),
        .count (count),
        .head  (head_e)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    assign dec.instr_valid = (count != '0);
    assign dec.instr       = head_e.instr;
    assign dec.instr_pc    = head_e.pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the PC controller. Watches the controller's `pc` output, issues one word request per new PC to instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small queue that feeds decode over valid/ready. A `flush` from branch resolution discards the queue and any in-flight request so that only post-redirect instructions reach decode.

## Interface
- `QDEPTH`, default 2: instruction queue entries (≥1).
- `clk  in  1`: system clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `pc  in  32`: current PC from the PC controller.
- `flush  in  1`: redirect or branch-taken; discard queued and in-flight fetches.
- `imem_req  out  1`: memory request; held until ack.
- `imem_addr  out  32`: request address; stable while `imem_req` is high.
- `imem_ack  in  1`: memory response strobe, one cycle.
- `imem_data  in  32`: instruction word, valid with `imem_ack`.
- `instr_valid  out  1`: queue head valid.
- `instr  out  32`: queue head instruction.
- `instr_pc  out  32`: PC of the queue head.
- `instr_ready  in  1`: decode accepts the head.

## Operation
- Registers: `state` ∈ {IDLE, REQ, DROP}, `last_pc` (32), `force` (1), queue with `count` (0..QDEPTH).
- Reset: state IDLE, `force`=1, `last_pc`=0, `count`=0. Outputs `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0.
- Fetch trigger, evaluated in IDLE only: `(pc != last_pc || force) && count < QDEPTH && !flush`.
- IDLE with trigger: go to REQ, `imem_addr`←pc, `last_pc`←pc, `force`←0, `imem_req`←1.
- REQ with `imem_ack` and no `flush`: push {`imem_addr`, `imem_data`}, drop `imem_req`, go to IDLE.
- REQ with `flush` and no ack: go to DROP. `imem_req` stays high because the memory transaction must complete.
- REQ with `flush` and `imem_ack` in the same cycle: discard the word, go to IDLE.
- DROP with `imem_ack`: discard, drop `imem_req`, go to IDLE. Any `flush` in DROP is absorbed.
- `flush`, in any state: `count`←0, `force`←1. The redirected `pc` is fetched even if it equals `last_pc`.
- `imem_ack` in IDLE is ignored. This covers a late ack after reset.
- Queue is a circular buffer. Pop on `instr_valid && instr_ready`. Push and pop in the same cycle are allowed at any count; `count` is unchanged.
- Space is checked at issue. Only one request is ever outstanding, and `count` cannot rise while in REQ, so a push never overflows.
- Flush has priority over push and pop in the same cycle: the queue ends empty.
- Address wrap: PC arithmetic belongs upstream. `pc`=32'hFFFF_FFFC is fetched like any other address.

## Timing
- `pc` changes at edge N: `imem_req`=1 and `imem_addr`=pc after edge N+1.
- Ack sampled at edge K: `instr_valid`=1 after edge K, with a registered head. Zero-wait memory (ack during the first REQ cycle) gives a 2-cycle pc-to-valid latency.
- Back-to-back issue: at most one fetch per two cycles (REQ→IDLE→REQ).
- `flush` at edge F: `instr_valid`=0 after F. The earliest re-issue is `imem_req` after F+1 if no request is in flight; otherwise after the ack is drained.
- `rst_n` low: immediate return to reset values, asynchronously, even mid-request. A memory still completing the abandoned transaction has its ack ignored.

## Structure
- Package `fetch_pkg`: state enum (IDLE, REQ, DROP), `INSTR_W`=32, `ADDR_W`=32.
- Sub-module `fetch_queue`:
  - Parameters: `QDEPTH`, width 64 (pc concatenated with instr).
  - Ports: push, pop, clear, count, head.
  - Same clk and `rst_n`.
- `fetch_unit` holds the FSM, trigger logic, and memory handshake.

## Test plan
- Reset, then `pc`=0x100 with zero-wait memory returning 0xAABB_CCDD. Required: `imem_addr`=0x100 after edge 1; after edge 2, `instr_valid`=1, `instr`=0xAABB_CCDD, `instr_pc`=0x100.
- Decode stalled (`instr_ready`=0) while `pc` steps 0x0, 0x4, 0x8. Required: two entries queued, no third request until a pop; after the pop the request for 0x8 issues.
- Ack delayed 3 cycles. Required: `imem_req` and `imem_addr` held stable throughout, `instr_valid` high only after the ack edge.
- `flush` pulses while in REQ and `pc` jumps to 0x400. Required: the late ack for the old address is discarded, the queue is emptied, then 0x400 is fetched and is the first valid `instr_pc`.
- `flush` with `pc` unchanged at 0x20. Required: `force` causes a refetch of 0x20.
- `rst_n` asserted mid-REQ, and an ack arrives one cycle after release. Required: all outputs at reset values, the ack is ignored, and a fresh fetch of the current `pc` issues.
